dmem_rmw_ctrl: RTL

Data-memory access controller for the RV32I softcore. It sits between the core's load/store unit and a single-port synchronous word RAM that has no byte enables. That RAM writes `di` and echoes it on `do` when `en`=1, and otherwise registers `RAM[addr]` onto `do` every cycle. The controller converts byte/halfword/word requests into word accesses, does read-modify-write for sub-word stores, and does lane extraction and sign/zero extension for loads.

---
 rtl/dmem_rmw_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rmw_ctrl
// Purpose  : Data-memory access controller between an RV32I load/store unit
//            and a single-port synchronous word RAM without byte enables.
//            Word stores are written directly; byte/halfword stores use a
//            read-modify-write sequence; loads select the addressed lane and
//            sign- or zero-extend it.
// Ports    :
//   clk, reset       clock; asynchronous active-high reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_we           1 = store, 0 = load
//   req_addr         byte address (DEPTH_LOG+2 bits)
//   req_size         00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned     load zero-extend (1) / sign-extend (0)
//   req_wdata        store data, value in the low bits
//   resp_valid       one-cycle completion pulse
//   resp_err         misaligned / illegal-size flag, valid with resp_valid
//   resp_rdata       load result or written word, held until next response
//   mem_en           RAM write strobe
//   mem_addr         RAM word address, registered at accept
//   mem_di           RAM write data
//   mem_do           RAM registered read data / write echo
// Revision : 1.0 - initial release
// ============================================================================
module dmem_rmw_ctrl #(
  parameter int DEPTH_LOG = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [DEPTH_LOG+1:0]   req_addr,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [31:0]            resp_rdata,
  output logic                   mem_en,
  output logic [DEPTH_LOG-1:0]   mem_addr,
  output logic [31:0]            mem_di,
  input  logic [31:0]            mem_do
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;

  logic        addr_err;
  logic [31:0] merged;
  logic [31:0] extracted;

  // Insert the store value into the addressed lane of the old word.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        ins  = {24'h0, wd[7:0]} << {lane, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        ins  = {16'h0, wd[15:0]} << {lane[1], 4'b0000};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        ins  = wd;
      end
    endcase
    return (old_w & ~mask) | ins;
  endfunction

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] extract_word(input logic [31:0] w,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
    logic [31:0] sh;
    logic [31:0] res;
    case (size)
      SZ_BYTE: begin
        sh  = w >> {lane, 3'b000};
        res = {{24{~uns & sh[7]}}, sh[7:0]};
      end
      SZ_HALF: begin
        sh  = w >> {lane[1], 4'b0000};
        res = {{16{~uns & sh[15]}}, sh[15:0]};
      end
      default: begin
        sh  = w;
        res = sh;
      end
    endcase
    return res;
  endfunction

  assign addr_err = (req_size == SZ_ILL)
                  | ((req_size == SZ_HALF) & req_addr[0])
                  | ((req_size == SZ_WORD) & (|req_addr[1:0]));

  assign merged    = merge_word(mem_do, wdata_q, size_q, lane_q);
  assign extracted = extract_word(mem_do, size_q, lane_q, uns_q);

  // Strobes decode straight from state so an asynchronous reset kills a
  // pending write immediately, before the edge that would commit it.
  assign req_ready = (state == IDLE);
  assign mem_en    = (state == WR) | ((state == MRG) & we_q);
  assign mem_di    = (state == WR) ? wdata_q : merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= 32'h0;
      mem_addr   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            lane_q   <= req_addr[1:0];
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata;
            mem_addr <= req_addr[DEPTH_LOG+1:2];
            if (addr_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_we && (req_size == SZ_WORD)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          state <= MRG;
        end
        MRG: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= we_q ? merged : extracted;
        end
        WR: begin
          // The RAM's write echo on mem_do only appears after this edge;
          // the captured store word is exactly what it will echo.
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= wdata_q;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
